// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg : shared UART types and constants (receiver state encoding)
// Revision : 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_IDLE = 3'd5
    } uart_rx_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_2ff : two-flop synchronizer with a configurable reset value
// Revision : 1.0
// ----------------------------------------------------------------------------
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx : 8N1/8E1 receiver, mid-bit sampling, framing and parity flags
// Revision : 1.0
// ----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic                      input_clk,
    input  logic                      nreset,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    output logic                      frame_err,
    output logic                      parity_err,
    output logic                      busy
);

    localparam int                 CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]   HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]   BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]         IDX_LAST  = 3'(UART_DATA_BITS - 1);

    generate
        if ((CLKS_PER_BIT < 4) || (CLKS_PER_BIT % 2 != 0)) begin : g_bad_clks_per_bit
            $error("uart_rx: CLKS_PER_BIT must be even and >= 4");
        end
    endgenerate

    uart_rx_state_e              state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [2:0]                  bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
    logic [UART_DATA_BITS-1:0]   data_q, data_d;
    logic                        perr_seen_q, perr_seen_d;
    logic                        valid_q, valid_d;
    logic                        ferr_q, ferr_d;
    logic                        perr_q, perr_d;
    logic                        rx_s;
    logic                        bit_done;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_i  (input_clk),
        .rst_ni (nreset),
        .d_i    (rx),
        .q_o    (rx_s)
    );

    always_ff @(posedge input_clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            perr_seen_q <= 1'b0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            perr_seen_q <= perr_seen_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
            perr_q      <= perr_d;
        end
    end

    assign bit_done = (cnt_q == BIT_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        perr_seen_d = perr_seen_q;
        valid_d     = 1'b0;
        ferr_d      = 1'b0;
        perr_d      = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    if (rx_s) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d     = RX_DATA;
                        cnt_d       = '0;
                        bit_idx_d   = '0;
                        perr_seen_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (bit_done) begin
                    shift_d[bit_idx_q] = rx_s;
                    cnt_d              = '0;
                    if (bit_idx_q == IDX_LAST) begin
                        if (PARITY_EN) state_d = RX_PARITY;
                        else           state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_PARITY: begin
                if (bit_done) begin
                    // Even parity: data bits plus parity bit must XOR to zero.
                    perr_seen_d = (^shift_q) ^ rx_s;
                    cnt_d       = '0;
                    state_d     = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = RX_IDLE;
                        if (perr_seen_q) begin
                            perr_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            data_d  = shift_q;
                        end
                    end else begin
                        // A low stop bit outranks any parity mismatch.
                        ferr_d  = 1'b1;
                        state_d = RX_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_WAIT_IDLE: begin
                if (rx_s) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != RX_IDLE);
        rx_data    = data_q;
        rx_valid   = valid_q;
        frame_err  = ferr_q;
        parity_err = perr_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_rx : directed frames into 8N1 and 8E1 receivers, checked per cycle
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_uart_rx;

    typedef struct {
        int         cyc;
        logic [2:0] kind;   // {valid, frame_err, parity_err}
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       nreset;
    logic       rx0, rx1;
    logic [7:0] rx_data0, rx_data1;
    logic       rx_valid0, rx_valid1;
    logic       frame_err0, frame_err1;
    logic       parity_err0, parity_err1;
    logic       busy0, busy1;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [7:0] exp_data0 = 8'h00;
    logic [7:0] exp_data1 = 8'h00;
    int   nv[2] = '{0, 0};
    int   nf[2] = '{0, 0};
    int   np[2] = '{0, 0};
    int   lv[2] = '{0, 0};

    uart_rx #(.CLKS_PER_BIT(16), .PARITY_EN(1'b0)) dut0 (
        .input_clk  (clk),
        .nreset     (nreset),
        .rx         (rx0),
        .rx_data    (rx_data0),
        .rx_valid   (rx_valid0),
        .frame_err  (frame_err0),
        .parity_err (parity_err0),
        .busy       (busy0)
    );

    uart_rx #(.CLKS_PER_BIT(16), .PARITY_EN(1'b1)) dut1 (
        .input_clk  (clk),
        .nreset     (nreset),
        .rx         (rx1),
        .rx_data    (rx_data1),
        .rx_valid   (rx_valid1),
        .frame_err  (frame_err1),
        .parity_err (parity_err1),
        .busy       (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    // Per-cycle comparison of pulses and held data against the expectation queues.
    always @(negedge clk) begin
        logic [2:0] e0k, e1k;
        e0k = 3'b000;
        e1k = 3'b000;
        if (!nreset) begin
            exp_data0 = 8'h00;
            exp_data1 = 8'h00;
        end
        if (q0.size() > 0 && q0[0].cyc == cyc) begin
            e0k = q0[0].kind;
            if (e0k == 3'b100) exp_data0 = q0[0].data;
            void'(q0.pop_front());
        end
        if (q1.size() > 0 && q1[0].cyc == cyc) begin
            e1k = q1[0].kind;
            if (e1k == 3'b100) exp_data1 = q1[0].data;
            void'(q1.pop_front());
        end
        check("flags0", {29'd0, rx_valid0, frame_err0, parity_err0}, {29'd0, e0k});
        check("data0", {24'd0, rx_data0}, {24'd0, exp_data0});
        check("flags1", {29'd0, rx_valid1, frame_err1, parity_err1}, {29'd0, e1k});
        check("data1", {24'd0, rx_data1}, {24'd0, exp_data1});
        if (rx_valid0 === 1'b1)   begin nv[0]++; lv[0] = cyc; end
        if (rx_valid1 === 1'b1)   begin nv[1]++; lv[1] = cyc; end
        if (frame_err0 === 1'b1)  nf[0]++;
        if (frame_err1 === 1'b1)  nf[1]++;
        if (parity_err0 === 1'b1) np[0]++;
        if (parity_err1 === 1'b1) np[1]++;
    end

    task automatic set_rx(input int d, input logic v);
        if (d == 0) rx0 = v;
        else        rx1 = v;
    endtask

    task automatic wait_cyc(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    // Drives one frame; e0 is the edge on which the receiver first sees the start bit.
    task automatic send_frame(input int d, input logic [7:0] data, input int bit_t,
                              input logic par_bit, input logic stop_bit, input int hold_t,
                              input bit expect_out, input bit align, output int e0);
        exp_t e;
        bit   par_en;
        par_en = (d == 1);
        if (align) begin
            @(posedge clk);
            #1;
        end
        e0 = cyc + 3;
        if (expect_out) begin
            e.cyc  = e0 + 152 + (par_en ? 16 : 0);
            e.data = data;
            if (!stop_bit)                           e.kind = 3'b010;
            else if (par_en && ((^data) ^ par_bit))  e.kind = 3'b001;
            else                                     e.kind = 3'b100;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        set_rx(d, 1'b0);
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            set_rx(d, data[i]);
            #(bit_t);
        end
        if (par_en) begin
            set_rx(d, par_bit);
            #(bit_t);
        end
        set_rx(d, stop_bit);
        #(bit_t);
        if (!stop_bit) #(hold_t);
        set_rx(d, 1'b1);
    endtask

    initial begin
        int e0, n, dummy;
        rx0    = 1'b1;
        rx1    = 1'b1;
        nreset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy0", {31'd0, busy0}, 32'd0);
        check("reset_busy1", {31'd0, busy1}, 32'd0);
        check("reset_data0", {24'd0, rx_data0}, 32'h00);
        nreset = 1'b1;
        repeat (5) @(posedge clk);

        // Ideal 8N1 frame
        send_frame(0, 8'hA5, 160, 1'b0, 1'b1, 0, 1'b1, 1'b1, e0);
        wait_cyc(e0 + 170);
        check("a5_latency", lv[0], e0 + 152);
        check("a5_data", {24'd0, rx_data0}, 32'hA5);
        check("a5_count", nv[0], 1);

        // Glitch shorter than half a bit
        @(posedge clk);
        #1;
        n   = cyc;
        rx0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rx0 = 1'b1;
        wait_cyc(n + 3);
        check("fs_busy_rise", {31'd0, busy0}, 32'd1);
        wait_cyc(n + 10);
        check("fs_busy_hold", {31'd0, busy0}, 32'd1);
        wait_cyc(n + 11);
        check("fs_busy_fall", {31'd0, busy0}, 32'd0);
        repeat (5) @(posedge clk);
        check("fs_data", {24'd0, rx_data0}, 32'hA5);
        check("fs_count", nv[0], 1);

        // Low stop bit, line held low 40 cycles beyond the stop bit
        send_frame(0, 8'h3C, 160, 1'b0, 1'b0, 400, 1'b1, 1'b1, e0);
        n = cyc;
        check("fe_busy_low_line", {31'd0, busy0}, 32'd1);
        wait_cyc(n + 2);
        check("fe_busy_before_idle", {31'd0, busy0}, 32'd1);
        wait_cyc(n + 3);
        check("fe_busy_after_idle", {31'd0, busy0}, 32'd0);
        check("fe_count", nf[0], 1);
        check("fe_data_held", {24'd0, rx_data0}, 32'hA5);
        repeat (5) @(posedge clk);

        // Even parity: 0x07 has three ones, so the parity bit must be 1
        send_frame(1, 8'h07, 160, 1'b1, 1'b1, 0, 1'b1, 1'b1, e0);
        wait_cyc(e0 + 185);
        check("par_ok_latency", lv[1], e0 + 168);
        check("par_ok_data", {24'd0, rx_data1}, 32'h07);
        send_frame(1, 8'h07, 160, 1'b0, 1'b1, 0, 1'b1, 1'b1, e0);
        wait_cyc(e0 + 185);
        check("par_bad_count", np[1], 1);
        check("par_bad_valid", nv[1], 1);
        check("par_bad_data", {24'd0, rx_data1}, 32'h07);

        // Back-to-back frames, fast then slow by about 3%
        send_frame(0, 8'h00, 155, 1'b0, 1'b1, 0, 1'b1, 1'b1, e0);
        send_frame(0, 8'hFF, 165, 1'b0, 1'b1, 0, 1'b1, 1'b0, e0);
        wait_cyc(e0 + 170);
        check("skew_count", nv[0], 3);
        check("skew_data", {24'd0, rx_data0}, 32'hFF);

        // Reset during data bit 4 of a frame that must produce nothing
        fork
            send_frame(0, 8'h96, 160, 1'b0, 1'b1, 0, 1'b0, 1'b1, dummy);
            begin
                repeat (95) @(posedge clk);
                #1;
                nreset = 1'b0;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy", {31'd0, busy0}, 32'd0);
        check("abort_data", {24'd0, rx_data0}, 32'h00);
        nreset = 1'b1;
        repeat (5) @(posedge clk);
        send_frame(0, 8'h5A, 160, 1'b0, 1'b1, 0, 1'b1, 1'b1, e0);
        wait_cyc(e0 + 170);
        check("after_abort_latency", lv[0], e0 + 152);
        check("after_abort_data", {24'd0, rx_data0}, 32'h5A);
        check("after_abort_count", nv[0], 4);
        check("no_stray_ferr", nf[0], 1);
        check("queue0_drained", q0.size(), 0);
        check("queue1_drained", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the UART link: recovers 8N1 frames (optionally 8E1) from the `rx` pin and presents each byte as a one-cycle-valid parallel word. It runs in the same `input_clk` domain as the clock divider and transmitter, and replaces the divided clock with an internal per-bit cycle counter. It samples each bit at its midpoint and flags framing and parity errors.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: `input_clk` cycles per serial bit. Must be even and ≥ 4.
- `PARITY_EN`, default 0: 1 = one even-parity bit between D7 and the stop bit.

Ports:
- `input_clk` (in, 1): sole clock. One clock; reset is asynchronous and active-low.
- `nreset` (in, 1): asynchronous, active-low reset.
- `rx` (in, 1): serial line, idle high, asynchronous to `input_clk`.
- `rx_data` (out, 8): last correctly framed byte, LSB first on the wire.
- `rx_valid` (out, 1): one-cycle pulse when `rx_data` updates.
- `frame_err` (out, 1): one-cycle pulse when the stop bit is sampled low.
- `parity_err` (out, 1): one-cycle pulse when the parity bit mismatches. Only when `PARITY_EN=1`.
- `busy` (out, 1): high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer; the output is `rx_s`. Synchronizer flops reset to 1.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- **IDLE**: on `rx_s==0`, go to START and set `cnt<=0`.
- **START**: increment `cnt`. At `cnt==CLKS_PER_BIT/2-1`, sample `rx_s`:
  - 1: false start, go to IDLE. No output pulses.
  - 0: set `cnt<=0`, `bit_idx<=0`, go to DATA.
- **DATA**: at `cnt==CLKS_PER_BIT-1`, shift `rx_s` into bit `bit_idx` of the shift register and reset `cnt`. After `bit_idx==7`, go to PARITY if `PARITY_EN`, else STOP.
- **PARITY**: at the same `cnt` point, check that the XOR of the 8 data bits and `rx_s` is 0. Record the mismatch, then go to STOP.
- **STOP**: at the same `cnt` point, sample `rx_s`:
  - 1 with no parity mismatch: load `rx_data` and pulse `rx_valid`. Go to IDLE.
  - 1 with a parity mismatch: pulse `parity_err`, leave `rx_data` unchanged. Go to IDLE.
  - 0: pulse `frame_err`, leave `rx_data` unchanged, suppress `parity_err`. Go to WAIT_IDLE.
- **WAIT_IDLE**: stay until `rx_s==1`, then go to IDLE. A break condition therefore produces exactly one `frame_err`.
- `rx_valid`, `frame_err` and `parity_err` are mutually exclusive and never high two cycles in a row.
- Width rule: `cnt` is `$clog2(CLKS_PER_BIT)` bits, `bit_idx` is 3 bits. Neither wraps except by explicit reset.

## Timing
- Reset (asynchronous, immediate): state IDLE, `rx_data=8'h00`, `rx_valid=0`, `frame_err=0`, `parity_err=0`, `busy=0`, `cnt=0`, `bit_idx=0`.
- Asserting `nreset` mid-frame aborts the frame with no pulse. After release, the receiver needs `rx_s` high for IDLE → START detection to resume normally; a low line at release is treated as a start edge.
- Pin-to-`rx_s` latency: 2 cycles.
- Reference edge E0 is the edge on which IDLE sees `rx_s==0`.
  - Start-bit sample: E0 + `CLKS_PER_BIT/2`.
  - Data bit i (i = 0..7): E0 + `CLKS_PER_BIT/2` + (i+1)·`CLKS_PER_BIT`.
  - Stop-bit sample (`PARITY_EN=0`): E0 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`.
  - With `PARITY_EN=1`, the stop-bit sample moves one `CLKS_PER_BIT` later.
- `rx_valid` / `frame_err` / `parity_err` are registered on the stop-sample edge and high for exactly one cycle.
- Back-to-back frames: IDLE is re-entered on the stop-sample edge, so a start bit arriving half a bit later is detected.
- No backpressure: consumers must take `rx_data` on the `rx_valid` cycle. `rx_data` holds until the next valid frame.

## Structure
- `uart_pkg` holds the `uart_rx_state_e` enum (shared naming style with the transmitter's state enum) and the `UART_DATA_BITS = 8` constant.
- One sub-module, `sync_2ff`: a reusable synchronizer with a reset value parameter, instantiated with reset value 1. The FSM, counters and shift register stay in `uart_rx`.

## Test plan
- Reset, then 8N1 frame `0xA5`, `CLKS_PER_BIT=16`, ideal timing → `rx_valid` exactly 152 cycles after E0, `rx_data=8'hA5`, no error pulses.
- `rx` low for 5 cycles, then high → `busy` rises, then falls at E0+8; no pulses, `rx_data` unchanged.
- Frame `0x3C` with stop bit forced low, line held low 40 more cycles → single `frame_err`, `rx_data` keeps its previous value, `busy` stays high until the line goes high.
- `PARITY_EN=1`: frame `0x07` with parity bit 1 → `rx_valid`, data `0x07`. Same frame with parity bit 0 → `parity_err`, no `rx_valid`.
- Two back-to-back frames `0x00`, `0xFF` with ±3% bit-period skew → two `rx_valid` pulses with correct data.
- `nreset` asserted at data bit 4, released with line idle, then frame `0x5A` → no pulse from the aborted frame; `rx_valid` with `0x5A`.
